// File: rtl/axi_bus_scheduler_if.sv
// Bundles the two master ports, the address-decoder handshake and the slave port of axi_bus_scheduler.
// The slave modport is the scheduler's view; the master modport is the surrounding system's view.
interface axi_bus_scheduler_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int SELECT    = 4
);
  logic                 m0_req;
  logic                 m1_req;
  logic                 m0_we;
  logic                 m1_we;
  logic [ADDR_SIZE-1:0] m0_addr;
  logic [ADDR_SIZE-1:0] m1_addr;
  logic [DATA_SIZE-1:0] m0_wdata;
  logic [DATA_SIZE-1:0] m1_wdata;
  logic                 m0_gnt;
  logic                 m1_gnt;
  logic                 m0_rvalid;
  logic                 m1_rvalid;
  logic [DATA_SIZE-1:0] m0_rdata;
  logic [DATA_SIZE-1:0] m1_rdata;
  logic                 m0_err;
  logic                 m1_err;

  logic [ADDR_SIZE-1:0] dec_addr_in;
  logic [SELECT-1:0]    dec_select;
  logic [ADDR_SIZE-1:0] dec_addr_out;

  logic                 s_req;
  logic [SELECT-1:0]    s_sel;
  logic [ADDR_SIZE-1:0] s_addr;
  logic                 s_we;
  logic [DATA_SIZE-1:0] s_wdata;
  logic                 s_rvalid;
  logic [DATA_SIZE-1:0] s_rdata;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_err, m1_err,
    output dec_addr_in,
    input  dec_select, dec_addr_out,
    output s_req, s_sel, s_addr, s_we, s_wdata,
    input  s_rvalid, s_rdata
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_err, m1_err,
    input  dec_addr_in,
    output dec_select, dec_addr_out,
    input  s_req, s_sel, s_addr, s_we, s_wdata,
    output s_rvalid, s_rdata
  );
endinterface

// File: rtl/axi_bus_scheduler.sv
// Two-master, single-outstanding bus scheduler: round-robin grant, external address decode,
// one slave access with a bounded wait, and a one-cycle response back to the granted master.
module axi_bus_scheduler #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int SELECT    = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  axi_bus_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [SELECT-1:0] UNMAPPED     = SELECT'(8);
  localparam logic [7:0]        TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 id_q, id_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [7:0]           cnt_q, cnt_d;

  logic grant0, grant1, issue;
  logic resp0, resp1;

  // prio_q set means m1 has priority; grants are held off while rst_n is low so outputs stay quiet.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    issue   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rst_n) begin
          grant0 = bus.m0_req && (!bus.m1_req || !prio_q);
          grant1 = bus.m1_req && (!bus.m0_req || prio_q);
        end
        if (grant0 || grant1) begin
          id_d    = grant1;
          we_d    = grant1 ? bus.m1_we    : bus.m0_we;
          addr_d  = grant1 ? bus.m1_addr  : bus.m0_addr;
          wdata_d = grant1 ? bus.m1_wdata : bus.m0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dec_select == UNMAPPED) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          issue   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.s_rvalid) begin
          rdata_d = we_q ? '0 : bus.s_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        prio_d  = ~id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp0 = (state_q == RESP) && !id_q;
  assign resp1 = (state_q == RESP) &&  id_q;

  assign bus.m0_gnt    = grant0;
  assign bus.m1_gnt    = grant1;
  assign bus.m0_rvalid = resp0;
  assign bus.m1_rvalid = resp1;
  assign bus.m0_rdata  = resp0 ? rdata_q : '0;
  assign bus.m1_rdata  = resp1 ? rdata_q : '0;
  assign bus.m0_err    = resp0 && err_q;
  assign bus.m1_err    = resp1 && err_q;

  assign bus.dec_addr_in = (state_q != IDLE) ? addr_q : '0;

  // Slave fields are only meaningful alongside the strobe, so they are zeroed otherwise.
  assign bus.s_req   = issue;
  assign bus.s_sel   = issue ? bus.dec_select   : '0;
  assign bus.s_addr  = issue ? bus.dec_addr_out : '0;
  assign bus.s_we    = issue && we_q;
  assign bus.s_wdata = issue ? wdata_q : '0;

endmodule

// File: tb/tb_axi_bus_scheduler.sv
// Randomized and directed bench for axi_bus_scheduler against a transaction-level model.
// The bench plays both masters, the address decoder and a slave with a programmable response delay.
module tb_axi_bus_scheduler;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_bus_scheduler_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .SELECT(SW)) bus ();

  axi_bus_scheduler #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .SELECT(SW), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Address map: top nibble 0..2 selects that slave with a 12-bit offset, anything else is unmapped.
  function automatic logic [SW-1:0] decSel(input logic [AW-1:0] a);
    return (a[31:28] >= 4'd3) ? 4'd8 : a[31:28];
  endfunction

  function automatic logic [AW-1:0] decAddr(input logic [AW-1:0] a);
    return (a[31:28] >= 4'd3) ? '0 : {20'h0, a[11:0]};
  endfunction

  always_comb begin
    bus.dec_select   = decSel(bus.dec_addr_in);
    bus.dec_addr_out = decAddr(bus.dec_addr_in);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit             pend [2];
  logic           pend_we [2];
  logic [AW-1:0]  pend_addr [2];
  logic [DW-1:0]  pend_wdata [2];

  bit             busy;
  int             last_served;
  int             t_id, t_g, t_r;
  bit             t_mapped;
  logic [AW-1:0]  t_addr;
  logic           t_we;
  logic [DW-1:0]  t_wdata;
  logic [DW-1:0]  t_rdata;
  bit             t_err;
  int             sresp_cycle;
  logic [DW-1:0]  sresp_data;
  int             force_k;
  bit             force_data_en;
  logic [DW-1:0]  force_data;
  bit             rand_reqs;
  bit             keep_both;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic newRequest(input int m, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    pend[m]       = 1'b1;
    pend_we[m]    = we;
    pend_addr[m]  = addr;
    pend_wdata[m] = wd;
  endtask

  task automatic randRequest(input int m);
    newRequest(m, 1'($urandom_range(0, 1)), {4'($urandom_range(0, 3)), 28'($urandom)}, DW'($urandom));
  endtask

  // One bus cycle: drive masters and slave, let the model decide any grant, then compare at negedge.
  task automatic applyStimulus();
    int  w;
    int  k;
    bit  exp_sreq, exp_rv0, exp_rv1;
    @(posedge clk);
    #1;
    cyc++;
    bus.m0_req   = pend[0];
    bus.m0_we    = pend_we[0];
    bus.m0_addr  = pend_addr[0];
    bus.m0_wdata = pend_wdata[0];
    bus.m1_req   = pend[1];
    bus.m1_we    = pend_we[1];
    bus.m1_addr  = pend_addr[1];
    bus.m1_wdata = pend_wdata[1];
    bus.s_rvalid = (cyc == sresp_cycle);
    bus.s_rdata  = bus.s_rvalid ? sresp_data : DW'($urandom);

    w = -1;
    if (!busy && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) w = (last_served == 0) ? 1 : 0;
      else                    w = pend[1] ? 1 : 0;
      busy     = 1'b1;
      t_id     = w;
      t_g      = cyc;
      t_addr   = pend_addr[w];
      t_we     = pend_we[w];
      t_wdata  = pend_wdata[w];
      t_mapped = (decSel(t_addr) != 4'd8);
      k        = (force_k >= 0) ? force_k : $urandom_range(0, 5);
      sresp_data = force_data_en ? force_data : DW'($urandom);
      if (!t_mapped) begin
        t_r = cyc + 2;
        t_err = 1'b1;
        t_rdata = '0;
        sresp_cycle = -100;
      end else begin
        sresp_cycle = cyc + 2 + k;
        if (k <= TMO - 1) begin
          t_r = cyc + 3 + k;
          t_err = 1'b0;
          t_rdata = t_we ? '0 : sresp_data;
        end else begin
          t_r = cyc + 2 + TMO;
          t_err = 1'b1;
          t_rdata = '0;
        end
      end
      force_k = -1;
      force_data_en = 1'b0;
    end

    @(negedge clk);
    checkOutput("m0_gnt", bus.m0_gnt, w == 0);
    checkOutput("m1_gnt", bus.m1_gnt, w == 1);
    exp_sreq = busy && t_mapped && (cyc == t_g + 1);
    checkOutput("s_req", bus.s_req, exp_sreq);
    if (exp_sreq) begin
      checkOutput("s_sel", bus.s_sel, decSel(t_addr));
      checkOutput("s_addr", bus.s_addr, decAddr(t_addr));
      checkOutput("s_we", bus.s_we, t_we);
      checkOutput("s_wdata", bus.s_wdata, t_wdata);
    end
    if (busy && cyc > t_g) checkOutput("dec_addr_in", bus.dec_addr_in, t_addr);
    exp_rv0 = busy && (cyc == t_r) && (t_id == 0);
    exp_rv1 = busy && (cyc == t_r) && (t_id == 1);
    checkOutput("m0_rvalid", bus.m0_rvalid, exp_rv0);
    checkOutput("m0_rdata", bus.m0_rdata, exp_rv0 ? t_rdata : '0);
    checkOutput("m0_err", bus.m0_err, exp_rv0 && t_err);
    checkOutput("m1_rvalid", bus.m1_rvalid, exp_rv1);
    checkOutput("m1_rdata", bus.m1_rdata, exp_rv1 ? t_rdata : '0);
    checkOutput("m1_err", bus.m1_err, exp_rv1 && t_err);

    if (w >= 0) begin
      pend[w] = 1'b0;
      if (keep_both) randRequest(w);
    end
    if (busy && cyc == t_r) begin
      last_served = t_id;
      busy = 1'b0;
    end
    if (rand_reqs) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 2) == 0) randRequest(m);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      applyStimulus();
      if (!busy && !pend[0] && !pend[1]) return;
    end
    checkOutput("drain_timeout", 1, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_m0_gnt"}, bus.m0_gnt, 0);
    checkOutput({tag, "_m1_gnt"}, bus.m1_gnt, 0);
    checkOutput({tag, "_m0_rvalid"}, bus.m0_rvalid, 0);
    checkOutput({tag, "_m1_rvalid"}, bus.m1_rvalid, 0);
    checkOutput({tag, "_m0_rdata"}, bus.m0_rdata, 0);
    checkOutput({tag, "_m1_rdata"}, bus.m1_rdata, 0);
    checkOutput({tag, "_m0_err"}, bus.m0_err, 0);
    checkOutput({tag, "_m1_err"}, bus.m1_err, 0);
    checkOutput({tag, "_s_req"}, bus.s_req, 0);
    checkOutput({tag, "_s_sel"}, bus.s_sel, 0);
    checkOutput({tag, "_s_addr"}, bus.s_addr, 0);
    checkOutput({tag, "_s_we"}, bus.s_we, 0);
    checkOutput({tag, "_s_wdata"}, bus.s_wdata, 0);
    checkOutput({tag, "_dec_addr_in"}, bus.dec_addr_in, 0);
  endtask

  // Requests and a stray slave response are held active through reset; none of them may leak out.
  task automatic applyReset(input bit late_rvalid);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    bus.s_rvalid = late_rvalid;
    bus.s_rdata = DW'($urandom);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkAllZero("rst");
    end
    busy = 1'b0;
    last_served = -1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    sresp_cycle = -100;
    force_k = -1;
    force_data_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    @(negedge clk);
    checkAllZero("post_rst");
    bus.s_rvalid = 1'b0;
  endtask

  initial begin
    bus.m0_req = 1'b0;  bus.m1_req = 1'b0;
    bus.m0_we = 1'b0;   bus.m1_we = 1'b0;
    bus.m0_addr = '0;   bus.m1_addr = '0;
    bus.m0_wdata = '0;  bus.m1_wdata = '0;
    bus.s_rvalid = 1'b0;
    bus.s_rdata = '0;
    pend[0] = 1'b0;     pend[1] = 1'b0;
    pend_we[0] = 1'b0;  pend_we[1] = 1'b0;
    pend_addr[0] = '0;  pend_addr[1] = '0;
    pend_wdata[0] = '0; pend_wdata[1] = '0;
    busy = 1'b0;
    last_served = -1;
    sresp_cycle = -100;
    force_k = -1;
    force_data_en = 1'b0;
    force_data = '0;
    rand_reqs = 1'b0;
    keep_both = 1'b0;

    applyReset(1'b0);

    $display("[TB] m0 read of a mapped address with an immediate slave response");
    force_k = 0;
    force_data_en = 1'b1;
    force_data = 32'hA5A5A5A5;
    newRequest(0, 1'b0, 32'h19101004, 32'h0);
    drain();

    $display("[TB] m1 write to an unmapped address");
    newRequest(1, 1'b1, 32'h30000000, 32'hDEADBEEF);
    drain();

    $display("[TB] slave never answers in time, late response afterwards");
    force_k = TMO + 1;
    newRequest(0, 1'b0, 32'h10000010, 32'h0);
    drain();
    repeat (3) applyStimulus();

    $display("[TB] slave answers on the timeout cycle");
    force_k = TMO - 1;
    force_data_en = 1'b1;
    force_data = 32'h5A5A1234;
    newRequest(1, 1'b0, 32'h20000ABC, 32'h0);
    drain();

    $display("[TB] both masters requesting continuously");
    keep_both = 1'b1;
    randRequest(0);
    randRequest(1);
    repeat (40) applyStimulus();
    keep_both = 1'b0;
    drain();

    $display("[TB] random traffic");
    rand_reqs = 1'b1;
    repeat (400) applyStimulus();
    rand_reqs = 1'b0;
    drain();

    $display("[TB] reset during WAIT followed by a stray slave response");
    force_k = TMO + 1;
    newRequest(1, 1'b0, 32'h10000020, 32'h0);
    repeat (4) applyStimulus();
    applyReset(1'b1);
    randRequest(0);
    randRequest(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/axi_bus_scheduler.md
AXI_BUS_SCHEDULER -- requirements
Module: axi_bus_scheduler

Interface
REQ-001 The module SHALL have parameter ADDR_SIZE, default 32, master/slave address width.
REQ-002 The module SHALL have parameter DATA_SIZE, default 32, data width.
REQ-003 The module SHALL have parameter SELECT, default 4, width of the decoder slave select.
REQ-004 The module SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before an error response (range 1..255).
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 m0_req, m1_req  input  1  master transaction request, held until granted.
REQ-008 m0_we, m1_we  input  1  1 = write, 0 = read.
REQ-009 m0_addr, m1_addr  input  ADDR_SIZE  master address.
REQ-010 m0_wdata, m1_wdata  input  DATA_SIZE  master write data.
REQ-011 m0_gnt, m1_gnt  output  1  one-cycle grant pulse; request fields are captured this cycle.
REQ-012 m0_rvalid, m1_rvalid  output  1  one-cycle response pulse.
REQ-013 m0_rdata, m1_rdata  output  DATA_SIZE  read data, valid with rvalid.
REQ-014 m0_err, m1_err  output  1  error flag, valid with rvalid.
REQ-015 dec_addr_in  output  ADDR_SIZE  latched address driven to the external address-map decoder.
REQ-016 dec_select  input  SELECT  decoder slave select; value 8 means unmapped.
REQ-017 dec_addr_out  input  ADDR_SIZE  decoder-translated slave address.
REQ-018 s_req  output  1  one-cycle slave request strobe.
REQ-019 s_sel  output  SELECT  target slave index.
REQ-020 s_addr, s_we, s_wdata  output  ADDR_SIZE/1/DATA_SIZE  slave transaction fields.
REQ-021 s_rvalid, s_rdata  input  1/DATA_SIZE  slave response.

Function
REQ-022 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with one transaction outstanding at a time.
REQ-023 IDLE: if any mN_req is high, the block SHALL pulse the gnt of the winner, latch its addr/we/wdata/id and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-024 Arbitration SHALL be round-robin: the master not most recently served has priority; after reset m0 has priority; a single requester always wins.
REQ-025 dec_addr_in SHALL equal the latched address whenever the state is not IDLE.
REQ-026 ISSUE with dec_select==8: s_req SHALL stay 0, the error flag is set, rdata=0, and the next state is RESP.
REQ-027 ISSUE with any other dec_select: s_req=1 for exactly one cycle with s_sel=dec_select, s_addr=dec_addr_out and latched we/wdata, the wait counter cleared, and the next state is WAIT.
REQ-028 WAIT: s_rvalid=1 SHALL capture s_rdata (or 0 if a write) with err=0 and go to RESP; otherwise the 8-bit counter increments.
REQ-029 A WAIT timeout (counter == TIMEOUT-1 with no s_rvalid) SHALL set err=1, rdata=0 and go to RESP.
REQ-030 If s_rvalid and the timeout occur in the same cycle, s_rvalid SHALL win.
REQ-031 RESP: only the latched master SHALL see rvalid=1 for one cycle with its rdata and err; the round-robin pointer is updated and the next state is IDLE.
REQ-032 Latency SHALL be: grant in cycle T, s_req in T+1, earliest rvalid in T+3 (s_rvalid in T+2).
REQ-033 s_rvalid outside WAIT SHALL be ignored.
REQ-034 mN_rdata/mN_err SHALL be 0 when the corresponding rvalid is 0.
REQ-035 New requests SHALL be granted only in IDLE, so a master requesting during RESP waits at least one cycle.

Reset
REQ-036 With rst_n low at a clock edge, the block SHALL enter IDLE with priority on m0, counter 0, and all outputs 0 (gnt, rvalid, rdata, err, s_req, s_sel, s_addr, s_we, s_wdata, dec_addr_in).
REQ-037 Reset mid-transaction SHALL abandon the transaction: no rvalid is issued and late s_rvalid is ignored.

Verification
REQ-038 m0 read 0x19101004, decoder sel=1/addr=0x004, slave returns 0xA5A5A5A5 at T+2 -> m0_gnt at T, s_req/s_sel=1/s_addr=0x004 at T+1, m0_rvalid with rdata 0xA5A5A5A5 and err=0 at T+3.
REQ-039 m0 and m1 request continuously from reset -> grants alternate m0, m1, m0, m1; each rvalid goes only to the granted master.
REQ-040 m1 write to 0x30000000 (dec_select=8) -> no s_req; m1_rvalid with err=1 and rdata=0 at T+2.
REQ-041 TIMEOUT=4, slave never responds -> m0_rvalid with err=1 exactly 4 WAIT cycles after s_req; a later s_rvalid is ignored.
REQ-042 s_rvalid on the timeout cycle -> err=0 and slave data returned.
REQ-043 rst_n low during WAIT, then s_rvalid -> no rvalid, all outputs 0, next request granted to m0.
